// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Control unit for a multicycle MIPS core. It sequences fetch, decode, execute,
// memory and write-back steps and drives the datapath mux selects and enables.
// Memory accesses use a ready handshake with a timeout. Branch-on-zero is
// resolved here into a single PC load enable. An unsupported instruction or a
// memory timeout parks the FSM in TRAP and sets a sticky flag there. Only reset
// leaves TRAP.
//
// All outputs are combinational from the current state plus op/funct/zero/
// mem_ready. They are forced to zero while reset is high.
//
// Optional feature macro: CTRL_PERF_CNT_EN
//   defined   -> instr_count counts retired instructions (wraps, cleared by reset)
//   undefined -> instr_count is tied to zero and no counter is built
//
// Parameters
//   ALUCTL_W   : alu_control width (codes sit in the 3 LSBs, upper bits 0)
//   WAIT_CNT_W : width of the memory wait counter
//   TIMEOUT    : wait-counter value at which a still-not-ready access traps
//                (must be < 2**WAIT_CNT_W)
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   op, funct         : opcode and R-type function field from the IR
//   zero              : ALU zero flag
//   mem_ready         : memory completes the current access this cycle
//   mem_req, iord, mem_write, ir_write            : memory / IR controls
//   mem_to_reg, reg_write, reg_dest               : register file controls
//   alu_src_a, alu_src_b, imm_sel, alu_control    : ALU operand / op selects
//   pc_src, pc_en     : PC source select and load enable (branch folded in)
//   state_o           : current state code
//   illegal_op        : sticky, unsupported instruction decoded
//   timeout_err       : sticky, memory access timed out
//   instr_count       : retired-instruction counter (optional feature)
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int ALUCTL_W   = 3,
    parameter int WAIT_CNT_W = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic [1:0]          reg_dest,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_sel,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic [3:0]          state_o,
    output logic                illegal_op,
    output logic                timeout_err,
    output logic [31:0]         instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_JAL     = 4'd11,
        S_JR      = 4'd12,
        S_TRAP    = 4'd13
    } state_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_SPEC2 = 6'h1c;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Function codes
    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // ALU operation codes
    localparam logic [2:0] ALU_NONE  = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SUB   = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_MUL   = 3'd6;
    localparam logic [2:0] ALU_PASSA = 3'd7;

    // Next state after DECODE. Unsupported encodings go to TRAP.
    function automatic state_e decode_next(input logic [5:0] opc, input logic [5:0] fn);
        state_e nxt;
        case (opc)
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_J:           nxt = S_JUMP;
            OP_JAL:         nxt = S_JAL;
            OP_RTYPE: begin
                case (fn)
                    FN_JR:                                  nxt = S_JR;
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  nxt = S_EXEC_R;
                    default:                                nxt = S_TRAP;
                endcase
            end
            OP_SPEC2: begin
                if (fn == FN_MUL) begin
                    nxt = S_EXEC_R;
                end else begin
                    nxt = S_TRAP;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: nxt = S_EXEC_I;
            OP_LW, OP_SW:   nxt = S_MEM_ADR;
            default:        nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    // R-type (and mul) instructions write rd; everything else writes rt.
    function automatic logic is_r_class(input logic [5:0] opc);
        return (opc == OP_RTYPE) || (opc == OP_SPEC2);
    endfunction

    // ALU operation for register-register instructions.
    function automatic logic [2:0] r_alu_code(input logic [5:0] opc, input logic [5:0] fn);
        logic [2:0] code;
        if (opc == OP_SPEC2) begin
            code = ALU_MUL;
        end else begin
            case (fn)
                FN_ADD:  code = ALU_ADD;
                FN_SUB:  code = ALU_SUB;
                FN_AND:  code = ALU_AND;
                FN_OR:   code = ALU_OR;
                FN_SLT:  code = ALU_SLT;
                default: code = ALU_NONE;
            endcase
        end
        return code;
    endfunction

    // ALU operation for immediate instructions (lui adds to a zero rs field).
    function automatic logic [2:0] i_alu_code(input logic [5:0] opc);
        logic [2:0] code;
        case (opc)
            OP_SLTI: code = ALU_SLT;
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Immediate extension: logical ops zero-extend, lui shifts into the top half.
    function automatic logic [1:0] i_imm_sel(input logic [5:0] opc);
        logic [1:0] sel;
        case (opc)
            OP_ANDI, OP_ORI: sel = 2'b01;
            OP_LUI:          sel = 2'b10;
            default:         sel = 2'b00;
        endcase
        return sel;
    endfunction

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    illegal_q, illegal_d;
    logic                    timeout_q, timeout_d;
    logic                    mem_wait_s;
    logic                    timeout_hit_s;

    // Internal (ungated) control values
    logic                    mem_req_s, iord_s, mem_write_s, ir_write_s;
    logic                    mem_to_reg_s, reg_write_s, alu_src_a_s, pc_en_s;
    logic [1:0]              reg_dest_s, alu_src_b_s, imm_sel_s, pc_src_s;
    logic [2:0]              alu_code_s;

    // Memory-waiting condition and timeout detection for the access states.
    always_comb begin
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: mem_wait_s = ~mem_ready;
            default:                     mem_wait_s = 1'b0;
        endcase
        timeout_hit_s = mem_wait_s && (wait_cnt_q == WAIT_CNT_W'(TIMEOUT));
    end

    // Next-state logic and sticky error flag updates.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit_s) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = decode_next(op, funct);
                if (decode_next(op, funct) == S_TRAP) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            S_MEM_ADR: begin
                if (op == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_hit_s) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit_s) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Wait counter restarts on every state change, counts not-ready cycles otherwise.
    always_comb begin
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_wait_s) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Datapath control decode from the current state and instruction fields.
    always_comb begin
        mem_req_s    = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        reg_dest_s   = 2'b00;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        imm_sel_s    = 2'b00;
        alu_code_s   = ALU_NONE;
        pc_src_s     = 2'b00;
        pc_en_s      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b01;
                alu_code_s  = ALU_ADD;
                // IR load and PC+4 only on the cycle the fetch completes
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_en_s    = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_en_s    = 1'b0;
                end
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm<<2) into ALUOut
                alu_src_b_s = 2'b11;
                alu_code_s  = ALU_ADD;
            end
            S_MEM_ADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_code_s  = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_s = 1'b1;
                alu_code_s  = r_alu_code(op, funct);
            end
            S_EXEC_I: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_code_s  = i_alu_code(op);
                imm_sel_s   = i_imm_sel(op);
            end
            S_ALU_WB: begin
                // Keep the execute-stage ALU selects so the result stays stable
                reg_write_s = 1'b1;
                alu_src_a_s = 1'b1;
                if (is_r_class(op)) begin
                    reg_dest_s = 2'b01;
                    alu_code_s = r_alu_code(op, funct);
                end else begin
                    alu_src_b_s = 2'b10;
                    alu_code_s  = i_alu_code(op);
                    imm_sel_s   = i_imm_sel(op);
                end
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_code_s  = ALU_SUB;
                pc_src_s    = 2'b01;
                pc_en_s     = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_src_s = 2'b10;
                pc_en_s  = 1'b1;
            end
            S_JAL: begin
                // Link value PC+4 passes straight through the ALU
                reg_write_s = 1'b1;
                reg_dest_s  = 2'b10;
                alu_code_s  = ALU_PASSA;
                pc_src_s    = 2'b10;
                pc_en_s     = 1'b1;
            end
            S_JR: begin
                pc_src_s = 2'b11;
                pc_en_s  = 1'b1;
            end
            default: begin
                pc_en_s = 1'b0;
            end
        endcase
    end

    // Reset forces every output low so no write can happen during the abort cycle.
    assign mem_req     = mem_req_s & ~reset;
    assign iord        = iord_s & ~reset;
    assign mem_write   = mem_write_s & ~reset;
    assign ir_write    = ir_write_s & ~reset;
    assign mem_to_reg  = mem_to_reg_s & ~reset;
    assign reg_write   = reg_write_s & ~reset;
    assign reg_dest    = reset ? 2'b00 : reg_dest_s;
    assign alu_src_a   = alu_src_a_s & ~reset;
    assign alu_src_b   = reset ? 2'b00 : alu_src_b_s;
    assign imm_sel     = reset ? 2'b00 : imm_sel_s;
    assign alu_control = reset ? '0 : ALUCTL_W'(alu_code_s);
    assign pc_src      = reset ? 2'b00 : pc_src_s;
    assign pc_en       = pc_en_s & ~reset;
    assign state_o     = reset ? 4'd0 : state_q;
    assign illegal_op  = illegal_q & ~reset;
    assign timeout_err = timeout_q & ~reset;

`ifdef CTRL_PERF_CNT_EN
    logic        retire_s;
    logic [31:0] instr_count_q, instr_count_d;

    // An instruction retires on its final transition back to FETCH.
    always_comb begin
        case (state_q)
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: retire_s = 1'b1;
            S_MEM_WR: retire_s = mem_ready;
            default:  retire_s = 1'b0;
        endcase
        if (retire_s) begin
            instr_count_d = instr_count_q + 32'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= 32'd0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = reset ? 32'd0 : instr_count_q;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_ctrl_fsm. Directed instructions followed by random
// instruction/handshake sequences, each compared cycle by cycle against a
// reference model. The model expands an instruction class into its list of
// visited states and looks up expected controls from a per-state table.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, iord, mem_write, ir_write, mem_to_reg, reg_write;
    logic [1:0]  reg_dest, alu_src_b, imm_sel, pc_src;
    logic        alu_src_a, pc_en;
    logic [2:0]  alu_control;
    logic [3:0]  state_o;
    logic        illegal_op, timeout_err;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic m_ill   = 1'b0;
    logic m_tmo   = 1'b0;
    int   m_count = 0;
    int   path[$];
    logic [11:0] legal [19];

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.ALUCTL_W(3), .WAIT_CNT_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .reg_dest(reg_dest), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_sel(imm_sel), .alu_control(alu_control),
        .pc_src(pc_src), .pc_en(pc_en), .state_o(state_o),
        .illegal_op(illegal_op), .timeout_err(timeout_err),
        .instr_count(instr_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] obs_ctrl();
        return {mem_req, iord, mem_write, ir_write, mem_to_reg, reg_write, reg_dest,
                alu_src_a, alu_src_b, imm_sel, alu_control, pc_src, pc_en};
    endfunction

    // ALU operation named by the instruction (1 add, 2 and, 3 or, 4 sub, 5 slt, 6 mul)
    function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h1c) return 3'd6;
        if (o == 6'h00) begin
            case (f)
                6'h22:   return 3'd4;
                6'h24:   return 3'd2;
                6'h25:   return 3'd3;
                6'h2a:   return 3'd5;
                default: return 3'd1;
            endcase
        end
        case (o)
            6'h0a:   return 3'd5;
            6'h0c:   return 3'd2;
            6'h0d:   return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [5:0] o);
        if (o == 6'h0c || o == 6'h0d) return 2'b01;
        if (o == 6'h0f) return 2'b10;
        return 2'b00;
    endfunction

    // Expected control word for one cycle in state st
    function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] o, input logic [5:0] f,
                                             input logic z, input logic rdy);
        logic mreq, io, mw, irw, m2r, rw, sa, pe;
        logic [1:0] rd, sb, im, ps;
        logic [2:0] alu;
        {mreq, io, mw, irw, m2r, rw, sa, pe} = 8'd0;
        {rd, sb, im, ps} = 8'd0;
        alu = 3'd0;
        case (st)
            0:  begin mreq = 1'b1; sb = 2'b01; alu = 3'd1; irw = rdy; pe = rdy; end
            1:  begin sb = 2'b11; alu = 3'd1; end
            2:  begin sa = 1'b1; sb = 2'b10; alu = 3'd1; end
            3:  begin mreq = 1'b1; io = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mreq = 1'b1; io = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; alu = alu_of(o, f); end
            7:  begin sa = 1'b1; sb = 2'b10; alu = alu_of(o, f); im = imm_of(o); end
            8:  begin
                    rw = 1'b1; sa = 1'b1; alu = alu_of(o, f);
                    if (o == 6'h00 || o == 6'h1c) rd = 2'b01;
                    else begin sb = 2'b10; im = imm_of(o); end
                end
            9:  begin sa = 1'b1; alu = 3'd4; ps = 2'b01; pe = (o == 6'h04) ? z : ~z; end
            10: begin ps = 2'b10; pe = 1'b1; end
            11: begin rw = 1'b1; rd = 2'b10; alu = 3'd7; ps = 2'b10; pe = 1'b1; end
            12: begin ps = 2'b11; pe = 1'b1; end
            default: alu = 3'd0;
        endcase
        return {mreq, io, mw, irw, m2r, rw, rd, sa, sb, im, alu, ps, pe};
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef CTRL_PERF_CNT_EN
        return 32'(m_count);
`else
        return 32'd0;
`endif
    endfunction

    // States an instruction visits, starting from FETCH
    task automatic build_path(input logic [5:0] o, input logic [5:0] f);
        path = '{0, 1};
        if (o == 6'h04 || o == 6'h05) path.push_back(9);
        else if (o == 6'h02) path.push_back(10);
        else if (o == 6'h03) path.push_back(11);
        else if (o == 6'h00 && f == 6'h08) path.push_back(12);
        else if ((o == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a)) ||
                 (o == 6'h1c && f == 6'h02)) begin path.push_back(6); path.push_back(8); end
        else if (o == 6'h08 || o == 6'h09 || o == 6'h0a || o == 6'h0c || o == 6'h0d || o == 6'h0f) begin
            path.push_back(7); path.push_back(8);
        end
        else if (o == 6'h23) begin path.push_back(2); path.push_back(3); path.push_back(4); end
        else if (o == 6'h2b) begin path.push_back(2); path.push_back(5); end
        else path.push_back(13);
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance to just after the edge
    task automatic cycle(input int st, input logic rdy, input int zsel);
        logic z;
        z = (zsel > 1) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        mem_ready = rdy;
        zero = z;
        #3;
        check_eq($sformatf("state st%0d", st), 32'(state_o), 32'(st));
        check_eq($sformatf("ctrl st%0d", st), 32'(obs_ctrl()), 32'(exp_ctrl(st, op, funct, z, rdy)));
        check_eq($sformatf("flags st%0d", st), {30'd0, illegal_op, timeout_err}, {30'd0, m_ill, m_tmo});
        check_eq("instr_count", instr_count, exp_count());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        #3;
        check_eq("rst state", 32'(state_o), 32'd0);
        check_eq("rst ctrl", 32'(obs_ctrl()), 32'd0);
        check_eq("rst flags", {30'd0, illegal_op, timeout_err}, 32'd0);
        check_eq("rst count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ill = 1'b0;
        m_tmo = 1'b0;
        m_count = 0;
    endtask

    task automatic trap_tail(input int zsel);
        for (int k = 0; k < 3; k++) cycle(13, 1'($urandom_range(0, 1)), zsel);
        do_reset();
    endtask

    // Run one instruction. fw/mw: not-ready cycles in FETCH / data access
    // (above TIMEOUT means the access never completes). abort_at: path index
    // at which reset is asserted instead (-1 for none).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                             input int fw, input int mw, input int abort_at);
        int st;
        int w;
        build_path(o, f);
        op = o;
        funct = f;
        for (int i = 0; i < path.size(); i++) begin
            st = path[i];
            if (i == abort_at) begin
                do_reset();
                return;
            end
            if (st == 13) begin
                m_ill = 1'b1;
                trap_tail(zsel);
                return;
            end
            if (st == 0 || st == 3 || st == 5) begin
                w = (st == 0) ? fw : mw;
                for (int k = 0; k < ((w > TIMEOUT) ? TIMEOUT + 1 : w); k++) cycle(st, 1'b0, zsel);
                if (w > TIMEOUT) begin
                    m_tmo = 1'b1;
                    trap_tail(zsel);
                    return;
                end
                cycle(st, 1'b1, zsel);
            end else begin
                cycle(st, 1'($urandom_range(0, 1)), zsel);
            end
        end
        m_count++;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return TIMEOUT + 1;
        if (r < 3) return TIMEOUT;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        logic [5:0] o, f;
        int pick;
        legal = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2a},
                  {6'h00, 6'h08}, {6'h1c, 6'h02}, {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h0a, 6'h00},
                  {6'h0c, 6'h00}, {6'h0d, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
                  {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}};
        op = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b0;
        reset = 1'b1;
        do_reset();

        // Directed scenarios
        run_instr(6'h00, 6'h20, 2, 0, 0, -1);        // add
        run_instr(6'h23, 6'h00, 2, 0, 3, -1);        // lw, 3 wait cycles in MEM_RD
        run_instr(6'h05, 6'h00, 1, 0, 0, -1);        // bne, zero=1 -> no branch
        run_instr(6'h05, 6'h00, 0, 0, 0, -1);        // bne, zero=0 -> branch
        run_instr(6'h04, 6'h00, 1, 0, 0, -1);        // beq taken
        run_instr(6'h00, 6'h20, 2, TIMEOUT + 1, 0, -1); // fetch timeout, then reset
        run_instr(6'h3f, 6'h00, 2, 0, 0, -1);        // illegal opcode
        run_instr(6'h03, 6'h00, 2, 0, 0, -1);        // jal
        run_instr(6'h00, 6'h20, 2, 0, 0, -1);        // add
        run_instr(6'h2b, 6'h00, 2, 0, 0, -1);        // sw
        run_instr(6'h02, 6'h00, 2, 0, 0, -1);        // j
        run_instr(6'h2b, 6'h00, 2, TIMEOUT, TIMEOUT, -1); // ready wins at the limit
        run_instr(6'h2b, 6'h00, 2, 1, TIMEOUT + 1, -1);   // store timeout
        run_instr(6'h23, 6'h00, 2, 0, 2, 3);         // reset during MEM_RD
        run_instr(6'h1c, 6'h02, 2, 0, 0, -1);        // mul

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 21);
            if (pick < 19) begin
                {o, f} = legal[pick];
                if (o != 6'h00 && o != 6'h1c) f = 6'($urandom_range(0, 63));
            end else begin
                o = 6'($urandom_range(0, 63));
                f = 6'($urandom_range(0, 63));
            end
            run_instr(o, f, 2, pick_wait(), pick_wait(),
                      ($urandom_range(0, 29) == 0) ? $urandom_range(0, 3) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
